brg_systolic_edge_port: RTL and testbench

BRG_SYSTOLIC_EDGE_PORT -- requirements
Module: brg_systolic_edge_port

---
 rtl/brg_systolic_edge_pkg.sv | 23 ++
 rtl/bsg_fifo_1r1w_small.sv | 60 ++++++
 rtl/brg_systolic_edge_port.sv | 129 ++++++++++++
 tb/tb_brg_systolic_edge_port.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/brg_systolic_edge_pkg.sv
// Shared widths, CSR word indices and message layout for the systolic edge port.
package brg_systolic_edge_pkg;

    localparam int brg_data_width_gp = 32;
    localparam int brg_addr_width_gp = 32;
    localparam int brg_tag_width_gp  = 6;
    localparam int brg_msg_width_gp  = brg_tag_width_gp + brg_data_width_gp;
    localparam int brg_fifo_els_gp   = 4;

    // CSR word index taken from address bits [4:2]
    localparam logic [2:0] CSR_TX_DATA = 3'd0;
    localparam logic [2:0] CSR_TX_TAG  = 3'd1;
    localparam logic [2:0] CSR_RX_DATA = 3'd2;
    localparam logic [2:0] CSR_RX_TAG  = 3'd3;
    localparam logic [2:0] CSR_STATUS  = 3'd4;
    localparam logic [2:0] CSR_TX_SENT = 3'd5;

    typedef struct packed {
        logic [brg_tag_width_gp-1:0]  tag;
        logic [brg_data_width_gp-1:0] data;
    } brg_msg_s;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small circular-buffer FIFO, ready_then_valid: the producer only asserts v_i when ready_o=1.
module bsg_fifo_1r1w_small #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         v_i,
    output logic                         ready_o,
    input  logic [width_p-1:0]           data_i,
    output logic                         v_o,
    output logic [width_p-1:0]           data_o,
    input  logic                         yumi_i,
    output logic [$clog2(els_p+1)-1:0]   count_o
);

    localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [cnt_w_lp-1:0] count_q, count_d;
    logic                push, pop;

    function automatic logic [ptr_w_lp-1:0] bump(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + 1'b1;
    endfunction

    assign ready_o = (count_q != cnt_w_lp'(els_p));
    assign v_o     = (count_q != '0);
    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;

    always_comb begin
        push    = v_i && !reset_i;
        pop     = yumi_i && !reset_i;
        wptr_d  = push ? bump(wptr_q) : wptr_q;
        rptr_d  = pop ? bump(rptr_q) : rptr_q;
        count_d = count_q + cnt_w_lp'(push) - cnt_w_lp'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/brg_systolic_edge_port.sv
// CSR-mapped edge port: TX queue feeds the systolic array, RX queue collects its output.
module brg_systolic_edge_port
    import brg_systolic_edge_pkg::*;
#(
    parameter int data_width_p = brg_data_width_gp,
    parameter int addr_width_p = brg_addr_width_gp,
    parameter int tag_width_p  = brg_tag_width_gp,
    parameter int msg_width_p  = tag_width_p + data_width_p,
    parameter int fifo_els_p   = brg_fifo_els_gp
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      in_v_i,
    output logic                      in_yumi_o,
    input  logic [addr_width_p-1:0]   in_addr_i,
    input  logic [data_width_p-1:0]   in_data_i,
    input  logic [data_width_p/8-1:0] in_mask_i,
    input  logic                      in_we_i,
    output logic                      returning_v_o,
    output logic [data_width_p-1:0]   returning_data_o,
    output logic [msg_width_p-1:0]    out_msg_o,
    output logic                      out_val_o,
    input  logic                      out_rdy_i,
    input  logic [msg_width_p-1:0]    in_msg_i,
    input  logic                      in_val_i,
    output logic                      in_rdy_o
);

    localparam int cnt_w_lp = $clog2(fifo_els_p + 1);

    logic [2:0]              idx;
    logic                    tx_write, accept, tx_push, tx_pop, rx_pop, rx_push;
    logic                    tx_ready, tx_v, rx_ready, rx_v;
    logic [msg_width_p-1:0]  rx_head;
    logic [cnt_w_lp-1:0]     tx_count, rx_count;
    logic [data_width_p-1:0] rd_data;

    logic [tag_width_p-1:0]  tag_q, tag_d;
    logic [31:0]             sent_q, sent_d;
    logic                    ret_v_q, ret_v_d;
    logic [data_width_p-1:0] ret_data_q, ret_data_d;

    logic unused_ok;
    assign unused_ok = ^{in_mask_i, in_addr_i[addr_width_p-1:5], in_addr_i[1:0]};

    assign idx = in_addr_i[4:2];

    // During reset the queues present as empty so the edge never sees stale traffic
    assign out_val_o = tx_v && !reset_i;
    assign in_rdy_o  = rx_ready || reset_i;

    always_comb begin
        tx_write  = in_v_i && in_we_i && (idx == CSR_TX_DATA);
        in_yumi_o = in_v_i && !(tx_write && !tx_ready && !reset_i);
        accept    = in_yumi_o && !reset_i;
        tx_push   = accept && tx_write;
        tx_pop    = out_val_o && out_rdy_i;
        rx_pop    = accept && !in_we_i && (idx == CSR_RX_DATA) && rx_v;
        rx_push   = in_val_i && in_rdy_o;
    end

    always_comb begin
        rd_data = '0;
        case (idx)
            CSR_TX_TAG:  rd_data[tag_width_p-1:0] = tag_q;
            CSR_RX_DATA: if (rx_v) rd_data = rx_head[data_width_p-1:0];
            CSR_RX_TAG:  if (rx_v) rd_data[tag_width_p-1:0] = rx_head[msg_width_p-1 -: tag_width_p];
            CSR_STATUS:  rd_data[15:0] = {8'(tx_count), 8'(rx_count)};
            CSR_TX_SENT: rd_data[31:0] = sent_q;
            default:     rd_data = '0;
        endcase
    end

    always_comb begin
        ret_v_d    = accept;
        ret_data_d = (accept && !in_we_i) ? rd_data : '0;
        tag_d      = (accept && in_we_i && (idx == CSR_TX_TAG)) ? in_data_i[tag_width_p-1:0] : tag_q;
        sent_d     = sent_q;
        if (tx_pop) begin
            sent_d = sent_q + 32'd1;
        end
        // A software clear outranks a handshake in the same cycle
        if (accept && in_we_i && (idx == CSR_TX_SENT)) begin
            sent_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tag_q      <= '0;
            sent_q     <= '0;
            ret_v_q    <= 1'b0;
            ret_data_q <= '0;
        end else begin
            tag_q      <= tag_d;
            sent_q     <= sent_d;
            ret_v_q    <= ret_v_d;
            ret_data_q <= ret_data_d;
        end
    end

    assign returning_v_o    = ret_v_q;
    assign returning_data_o = ret_data_q;

    bsg_fifo_1r1w_small #(.width_p(msg_width_p), .els_p(fifo_els_p)) tx_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (tx_push),
        .ready_o (tx_ready),
        .data_i  ({tag_q, in_data_i}),
        .v_o     (tx_v),
        .data_o  (out_msg_o),
        .yumi_i  (tx_pop),
        .count_o (tx_count)
    );

    bsg_fifo_1r1w_small #(.width_p(msg_width_p), .els_p(fifo_els_p)) rx_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (rx_push),
        .ready_o (rx_ready),
        .data_i  (in_msg_i),
        .v_o     (rx_v),
        .data_o  (rx_head),
        .yumi_i  (rx_pop),
        .count_o (rx_count)
    );

endmodule

// File: tb/tb_brg_systolic_edge_port.sv
// Directed plus random stimulus against a queue-level reference model of the edge port.
module tb_brg_systolic_edge_port;
    import brg_systolic_edge_pkg::*;

    logic        clk = 1'b0;
    logic        rst, in_v, yumi, we, ret_v, out_val, out_rdy, in_val, in_rdy;
    logic [31:0] addr, wdata, ret_d;
    logic [3:0]  mask;
    logic [2:0]  idx;
    logic [37:0] out_msg, in_msg;

    int checks = 0;
    int errors = 0;

    brg_msg_s    tx_m[$];
    brg_msg_s    rx_m[$];
    logic [5:0]  tag_m;
    logic [31:0] sent_m;
    logic [31:0] last_ret;

    always #5 clk = ~clk;

    brg_systolic_edge_port #(
        .data_width_p (32),
        .addr_width_p (32),
        .tag_width_p  (6),
        .msg_width_p  (38),
        .fifo_els_p   (4)
    ) dut (
        .clk_i            (clk),
        .reset_i          (rst),
        .in_v_i           (in_v),
        .in_yumi_o        (yumi),
        .in_addr_i        (addr),
        .in_data_i        (wdata),
        .in_mask_i        (mask),
        .in_we_i          (we),
        .returning_v_o    (ret_v),
        .returning_data_o (ret_d),
        .out_msg_o        (out_msg),
        .out_val_o        (out_val),
        .out_rdy_i        (out_rdy),
        .in_msg_i         (in_msg),
        .in_val_i         (in_val),
        .in_rdy_o         (in_rdy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: check edge/CSR outputs before the edge, advance the model, check the response after.
    task automatic cycle();
        bit          acc, txw, exp_rv_v;
        logic [31:0] rv, exp_rv_d;
        int          ntx, nrx;
        #1;
        ntx = tx_m.size();
        nrx = rx_m.size();
        txw = in_v && we && (idx == 3'd0);
        acc = in_v && !(txw && ntx == 4 && !rst);
        check("in_yumi", yumi, acc);
        check("out_val", out_val, (!rst && ntx > 0));
        check("in_rdy", in_rdy, (rst || nrx < 4));
        if (!rst && ntx > 0) check("out_msg", out_msg, tx_m[0]);
        rv = 32'h0;
        case (idx)
            3'd1: rv = {26'h0, tag_m};
            3'd2: if (nrx > 0) rv = rx_m[0].data;
            3'd3: if (nrx > 0) rv = {26'h0, rx_m[0].tag};
            3'd4: rv = {16'h0, 8'(ntx), 8'(nrx)};
            3'd5: rv = sent_m;
            default: rv = 32'h0;
        endcase
        exp_rv_v = acc && !rst;
        exp_rv_d = (acc && !rst && !we) ? rv : 32'h0;
        if (rst) begin
            tx_m.delete();
            rx_m.delete();
            tag_m  = 6'h0;
            sent_m = 32'h0;
        end else begin
            if (ntx > 0 && out_rdy) begin
                void'(tx_m.pop_front());
                sent_m = sent_m + 32'd1;
            end
            if (acc && txw) tx_m.push_back('{tag_m, wdata});
            if (acc && we && idx == 3'd1) tag_m = wdata[5:0];
            if (acc && we && idx == 3'd5) sent_m = 32'h0;
            if (acc && !we && idx == 3'd2 && nrx > 0) void'(rx_m.pop_front());
            if (in_val && nrx < 4) rx_m.push_back(in_msg);
        end
        @(posedge clk);
        @(negedge clk);
        check("ret_v", ret_v, exp_rv_v);
        check("ret_data", ret_d, exp_rv_d);
        last_ret = ret_d;
    endtask

    task automatic set_req(input logic w, input logic [2:0] i, input logic [31:0] d);
        in_v  = 1'b1;
        we    = w;
        idx   = i;
        wdata = d;
        addr  = ($urandom & 32'hFFFF_FFE3) | {27'h0, i, 2'b00};
    endtask

    task automatic req(input logic w, input logic [2:0] i, input logic [31:0] d);
        set_req(w, i, d);
        cycle();
        in_v = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_v = 1'b0; we = 1'b0; idx = 3'd0; addr = 32'h0; wdata = 32'h0;
        mask = 4'hF; out_rdy = 1'b0; in_val = 1'b0; in_msg = 38'h0;
        tag_m = 6'h0; sent_m = 32'h0; last_ret = 32'h0;
        @(negedge clk);

        // Reset with a request in flight: no response, no side effect
        set_req(1'b1, CSR_TX_DATA, 32'hAAAA_5555);
        cycle();
        cycle();
        rst = 1'b0;
        in_v = 1'b0;
        req(1'b0, CSR_STATUS, 32'h0);
        check("reset_status", last_ret, 32'h0);

        // Tagged TX with one-cycle latency and TX_SENT
        out_rdy = 1'b1;
        req(1'b1, CSR_TX_TAG, 32'h0000_002A);
        req(1'b1, CSR_TX_DATA, 32'h0000_1234);
        #1;
        check("s1_out_msg", out_msg, 38'h2A_0000_1234);
        check("s1_out_val", out_val, 1'b1);
        cycle();
        req(1'b0, CSR_TX_SENT, 32'h0);
        check("s1_tx_sent", last_ret, 32'h1);
        req(1'b0, CSR_TX_TAG, 32'h0);
        check("s1_tag_read", last_ret, 32'h2A);

        // TX back-pressure: fifth write stalls until one handshake frees a slot
        out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) req(1'b1, CSR_TX_DATA, $urandom);
        req(1'b0, CSR_STATUS, 32'h0);
        check("s2_status_full", last_ret, 32'h0000_0400);
        set_req(1'b1, CSR_TX_DATA, $urandom);
        cycle();
        cycle();
        out_rdy = 1'b1;
        #1;
        check("s2_stall_pop_cycle", yumi, 1'b0);
        cycle();
        out_rdy = 1'b0;
        cycle();
        in_v = 1'b0;
        req(1'b0, CSR_STATUS, 32'h0);
        check("s2_status_refill", last_ret, 32'h0000_0400);
        out_rdy = 1'b1;
        for (int i = 0; i < 5; i++) cycle();
        out_rdy = 1'b0;

        // RX tag/data reads and empty-queue read
        in_val = 1'b1;
        in_msg = 38'h05_DEAD_BEEF;
        cycle();
        in_val = 1'b0;
        req(1'b0, CSR_RX_TAG, 32'h0);
        check("s3_rx_tag", last_ret, 32'h5);
        req(1'b0, CSR_RX_DATA, 32'h0);
        check("s3_rx_data", last_ret, 32'hDEAD_BEEF);
        req(1'b0, CSR_RX_DATA, 32'h0);
        check("s3_rx_empty", last_ret, 32'h0);
        req(1'b0, CSR_STATUS, 32'h0);
        check("s3_status", last_ret, 32'h0);

        // Full RX queue with a same-cycle CSR pop and incoming message
        in_val = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_msg = {$urandom, $urandom};
            cycle();
        end
        in_msg = {$urandom, $urandom};
        set_req(1'b0, CSR_RX_DATA, 32'h0);
        #1;
        check("s4_rdy_pop_cycle", in_rdy, 1'b0);
        cycle();
        in_v = 1'b0;
        #1;
        check("s4_rdy_next", in_rdy, 1'b1);
        cycle();
        in_val = 1'b0;
        for (int i = 0; i < 4; i++) req(1'b0, CSR_RX_DATA, 32'h0);
        req(1'b0, CSR_STATUS, 32'h0);
        check("s4_status", last_ret, 32'h0);

        // TX_SENT wrap and clear-wins
        req(1'b1, CSR_TX_DATA, $urandom);
        sent_m = 32'hFFFF_FFFF;
        force dut.sent_q = 32'hFFFF_FFFF;
        #1;
        release dut.sent_q;
        out_rdy = 1'b1;
        cycle();
        out_rdy = 1'b0;
        req(1'b0, CSR_TX_SENT, 32'h0);
        check("s5_wrap", last_ret, 32'h0);
        req(1'b1, CSR_TX_DATA, $urandom);
        req(1'b1, CSR_TX_DATA, $urandom);
        out_rdy = 1'b1;
        req(1'b1, CSR_TX_SENT, $urandom);
        out_rdy = 1'b0;
        req(1'b0, CSR_TX_SENT, 32'h0);
        check("s5_clear_wins", last_ret, 32'h0);

        // Reset mid-transfer with TX and RX entries queued
        in_val = 1'b1;
        in_msg = {$urandom, $urandom};
        req(1'b1, CSR_TX_DATA, $urandom);
        in_val = 1'b0;
        req(1'b1, CSR_TX_DATA, $urandom);
        rst = 1'b1;
        set_req(1'b0, CSR_STATUS, 32'h0);
        cycle();
        rst = 1'b0;
        in_v = 1'b0;
        #1;
        check("s6_out_val", out_val, 1'b0);
        check("s6_in_rdy", in_rdy, 1'b1);
        cycle();
        req(1'b0, CSR_STATUS, 32'h0);
        check("s6_status", last_ret, 32'h0);

        // Random traffic across all CSR indices
        for (int n = 0; n < 300; n++) begin
            rst     = ($urandom_range(0, 63) == 0);
            in_val  = $urandom_range(0, 1);
            in_msg  = {$urandom, $urandom};
            out_rdy = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) begin
                set_req($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom);
            end else begin
                in_v = 1'b0;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
